// File: rtl/ste_snd_pkg.sv
// Shared types and constants for the shifter-side sound sink: rate codes,
// rate-divider terminal counts and the FIFO pointer width helper.
package ste_snd_pkg;

  typedef enum logic [1:0] {
    RATE_6K  = 2'b00,
    RATE_12K = 2'b01,
    RATE_25K = 2'b10,
    RATE_50K = 2'b11
  } rate_e;

  localparam int DIV_W = 11;
  localparam logic [DIV_W-1:0] DIV_TERM_6K  = 11'd1280;
  localparam logic [DIV_W-1:0] DIV_TERM_12K = 11'd640;
  localparam logic [DIV_W-1:0] DIV_TERM_25K = 11'd320;
  localparam logic [DIV_W-1:0] DIV_TERM_50K = 11'd160;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [DIV_W-1:0] div_term(input rate_e r);
    logic [DIV_W-1:0] t;
    case (r)
      RATE_6K:  t = DIV_TERM_6K;
      RATE_12K: t = DIV_TERM_12K;
      RATE_25K: t = DIV_TERM_25K;
      RATE_50K: t = DIV_TERM_50K;
      default:  t = DIV_TERM_50K;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/snd_rate_div.sv
// Sample-rate prescaler: counts 8 MHz enables and pulses tick once per
// programmed period. A new rate is only adopted at a period boundary.
module snd_rate_div
  import ste_snd_pkg::*;
(
  input  logic       clk32,
  input  logic       rst,
  input  logic       mhz8_en1,
  input  logic       run,
  input  logic [1:0] rate,
  output logic       tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d, term_q, term_d, term;

  always_comb begin
    // While the count sits at zero the live rate is used, so a change can never cut a period short.
    term   = (cnt_q == '0) ? div_term(rate_e'(rate)) : term_q;
    term_d = term;
    tick   = run & mhz8_en1 & (cnt_q == term - DIV_W'(1));
    cnt_d  = cnt_q;
    if (!run || tick)   cnt_d = '0;
    else if (mhz8_en1)  cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      term_q <= DIV_TERM_6K;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
    end
  end

endmodule

// File: rtl/ste_snd_fifo.sv
// Shifter-side sound DMA sink: requests words, buffers DEPTH words and replays
// signed 8-bit samples at the programmed rate. Define SND_MONO_EN for packed mono playback.
module ste_snd_fifo
  import ste_snd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk32,
  input  logic        rst,
  input  logic        mhz8_en1,
  input  logic        sndon,
  input  logic [1:0]  rate,
  input  logic        mono,
  input  logic        sload_n,
  input  logic [15:0] din,
  output logic        sreq,
  output logic [7:0]  left,
  output logic [7:0]  right,
  output logic        smp_stb,
  output logic        underrun,
  output logic        overrun
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] TWO  = CW'(2);

  logic                   tick, wr, pop;
  logic                   sload_q, sload_d, ld_vld_q, ld_vld_d;
  logic [15:0]            ld_data_q, ld_data_d, head;
  logic [DEPTH-1:0][15:0] mem_q, mem_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   sreq_q, sreq_d, stb_q, stb_d, unr_q, unr_d, ovr_q, ovr_d;
  logic [7:0]             left_q, left_d, right_q, right_d;
`ifdef SND_MONO_EN
  logic                   phase_q, phase_d;
`else
  logic                   unused_mono;
  assign unused_mono = mono;
`endif

  snd_rate_div u_div (
    .clk32    (clk32),
    .rst      (rst),
    .mhz8_en1 (mhz8_en1),
    .run      (sndon),
    .rate     (rate),
    .tick     (tick)
  );

  always_comb begin
    sload_d   = sload_n;
    ld_vld_d  = sndon & sload_q & ~sload_n;
    ld_data_d = (sload_q & ~sload_n) ? din : ld_data_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    left_d    = left_q;
    right_d   = right_q;
    unr_d     = unr_q;
    ovr_d     = ovr_q;
    stb_d     = 1'b0;
    wr        = 1'b0;
    pop       = 1'b0;
    head      = mem_q[rd_ptr_q];
`ifdef SND_MONO_EN
    phase_d   = phase_q;
`endif

    // Emptiness is judged on the registered count: a same-cycle write is not bypassed.
    if (tick) begin
      if (count_q == '0) begin
        unr_d = 1'b1;
      end else begin
        stb_d = 1'b1;
`ifdef SND_MONO_EN
        if (mono && !phase_q) begin
          left_d  = head[15:8];
          right_d = head[15:8];
          phase_d = 1'b1;
        end else if (mono) begin
          left_d  = head[7:0];
          right_d = head[7:0];
          phase_d = 1'b0;
          pop     = 1'b1;
        end else begin
          left_d  = head[15:8];
          right_d = head[7:0];
          phase_d = 1'b0;
          pop     = 1'b1;
        end
`else
        left_d  = head[15:8];
        right_d = head[7:0];
        pop     = 1'b1;
`endif
      end
    end

    if (ld_vld_q) begin
      if (count_q == FULL) begin
        ovr_d = 1'b1;
      end else begin
        wr              = 1'b1;
        mem_d[wr_ptr_q] = ld_data_q;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    count_d = count_q + CW'(wr) - CW'(pop);
    sreq_d  = sndon & ((FULL - count_d) >= TWO);

    if (!sndon) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ld_vld_d = 1'b0;
      left_d   = '0;
      right_d  = '0;
      stb_d    = 1'b0;
      unr_d    = 1'b0;
      ovr_d    = 1'b0;
      sreq_d   = 1'b0;
`ifdef SND_MONO_EN
      phase_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      sload_q   <= 1'b1;
      ld_vld_q  <= 1'b0;
      ld_data_q <= '0;
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sreq_q    <= 1'b0;
      stb_q     <= 1'b0;
      unr_q     <= 1'b0;
      ovr_q     <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
`ifdef SND_MONO_EN
      phase_q   <= 1'b0;
`endif
    end else begin
      sload_q   <= sload_d;
      ld_vld_q  <= ld_vld_d;
      ld_data_q <= ld_data_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sreq_q    <= sreq_d;
      stb_q     <= stb_d;
      unr_q     <= unr_d;
      ovr_q     <= ovr_d;
      left_q    <= left_d;
      right_q   <= right_d;
`ifdef SND_MONO_EN
      phase_q   <= phase_d;
`endif
    end
  end

  // Dropping sreq combinationally on sndon keeps a stopped DMA from seeing one stale request.
  assign sreq     = sreq_q & sndon;
  assign left     = left_q;
  assign right    = right_q;
  assign smp_stb  = stb_q;
  assign underrun = unr_q;
  assign overrun  = ovr_q;

endmodule
